// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS-style control sequencer: one state register, with all datapath
// controls decoded combinationally from the state, the instruction fields and mem_ready.
module mc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic [3:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] Mem2Reg,
  output logic [1:0] RegDst,
  output logic [3:0] state,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB   = 4'd7,
    S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13, S_HALT   = 4'd14
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  function automatic logic funct_legal(input logic [5:0] fn);
    case (fn)
      F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_JR: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] fn);
    case (fn)
      F_ADD:   return ALU_ADD;
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_SLT:   return ALU_SLT;
      F_SLL:   return ALU_SLL;
      F_SRL:   return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

  state_t r_state;
  state_t w_next;

  // State register; reset lands in FETCH so the first fetch starts on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode; everything is held at 0 while rst_n is low.
  always_comb begin
    w_next     = r_state;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 2'b00;
    ALUControl = 4'b0000;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    RegWrite   = 1'b0;
    Mem2Reg    = 2'b00;
    RegDst     = 2'b00;
    halted     = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          ALUSrcB    = 2'b01;
          ALUControl = ALU_ADD;
          IRWrite    = mem_ready;
          PCWrite    = mem_ready;
          if (mem_ready) begin
            w_next = S_DECODE;
          end else begin
            w_next = S_FETCH;
          end
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          ALUControl = ALU_ADD;
          case (Opcode)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_RTYPE: begin
              if (Funct == F_JR) begin
                w_next = S_JR;
              end else if (funct_legal(Funct)) begin
                w_next = S_REXEC;
              end else begin
                w_next = S_HALT;
              end
            end
            OP_ADDI: w_next = S_IEXEC;
            OP_BEQ:  w_next = S_BRANCH;
            OP_J:    w_next = S_JUMP;
            OP_JAL:  w_next = S_JAL;
            default: w_next = S_HALT;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b10;
          ALUControl = ALU_ADD;
          // The instruction register still holds lw/sw here, so its opcode picks the access.
          if (Opcode == OP_SW) begin
            w_next = S_MEMWR;
          end else begin
            w_next = S_MEMRD;
          end
        end
        S_MEMRD: begin
          IorD = 1'b1;
          if (mem_ready) begin
            w_next = S_MEMWB;
          end else begin
            w_next = S_MEMRD;
          end
        end
        S_MEMWB: begin
          Mem2Reg  = 2'b01;
          RegWrite = 1'b1;
          w_next   = S_FETCH;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (mem_ready) begin
            w_next = S_FETCH;
          end else begin
            w_next = S_MEMWR;
          end
        end
        S_REXEC: begin
          ALUSrcA    = ((Funct == F_SLL) || (Funct == F_SRL)) ? 2'b10 : 2'b01;
          ALUControl = funct_alu(Funct);
          w_next     = S_RWB;
        end
        S_RWB: begin
          RegDst   = 2'b01;
          RegWrite = 1'b1;
          w_next   = S_FETCH;
        end
        S_IEXEC: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b10;
          ALUControl = ALU_ADD;
          w_next     = S_IWB;
        end
        S_IWB: begin
          RegWrite = 1'b1;
          w_next   = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 2'b01;
          ALUControl = ALU_SUB;
          PCSrc      = 2'b01;
          Branch     = 1'b1;
          w_next     = S_FETCH;
        end
        S_JUMP: begin
          PCSrc   = 2'b10;
          PCWrite = 1'b1;
          w_next  = S_FETCH;
        end
        S_JAL: begin
          PCSrc    = 2'b10;
          PCWrite  = 1'b1;
          RegDst   = 2'b10;
          Mem2Reg  = 2'b10;
          RegWrite = 1'b1;
          w_next   = S_FETCH;
        end
        S_JR: begin
          PCSrc   = 2'b11;
          PCWrite = 1'b1;
          w_next  = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
          w_next = S_HALT;
        end
        default: begin
          w_next = S_HALT;
        end
      endcase
    end else begin
      w_next = S_FETCH;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: instruction table, randomized mem_ready against a path-queue
// reference model, and hand-written reset / wait / halt sequences.
module tb_mc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IorD, MemWrite, IRWrite, PCWrite, Branch, RegWrite, halted;
  logic [1:0] PCSrc, ALUSrcA, ALUSrcB, Mem2Reg, RegDst;
  logic [3:0] ALUControl, state;

  always #5 clk = ~clk;

  mc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .PCSrc(PCSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .Mem2Reg(Mem2Reg), .RegDst(RegDst),
    .state(state), .halted(halted)
  );

  typedef struct packed {
    logic       iord, memwrite, irwrite, pcwrite, branch;
    logic [1:0] pcsrc;
    logic [3:0] aluc;
    logic [1:0] srca, srcb;
    logic       regwrite;
    logic [1:0] m2r, regdst;
    logic       halted;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         lat;
    int         exec_st;
  } vec_t;

  ctrl_t act_c;
  assign act_c = {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUControl,
                  ALUSrcA, ALUSrcB, RegWrite, Mem2Reg, RegDst, halted};

  int    checks = 0;
  int    errors = 0;
  int    exp_q[$];
  int    dut_st;
  int    mw_cnt;
  vec_t  tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2A:   return 4'b0111;
      6'h00:   return 4'b1000;
      6'h02:   return 4'b1001;
      default: return 4'b0010;
    endcase
  endfunction

  // Control word the spec's per-state table demands.
  function automatic ctrl_t exp_ctrl(input int s, input logic [5:0] fn, input logic mr);
    ctrl_t c;
    c = '0;
    case (s)
      0:  begin c.srcb = 2'b01; c.aluc = 4'b0010; c.irwrite = mr; c.pcwrite = mr; end
      1:  begin c.srcb = 2'b11; c.aluc = 4'b0010; end
      2:  begin c.srca = 2'b01; c.srcb = 2'b10; c.aluc = 4'b0010; end
      3:  c.iord = 1'b1;
      4:  begin c.m2r = 2'b01; c.regwrite = 1'b1; end
      5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      6:  begin c.srca = (fn == 6'h00 || fn == 6'h02) ? 2'b10 : 2'b01; c.aluc = alu_of(fn); end
      7:  begin c.regdst = 2'b01; c.regwrite = 1'b1; end
      8:  begin c.srca = 2'b01; c.srcb = 2'b10; c.aluc = 4'b0010; end
      9:  c.regwrite = 1'b1;
      10: begin c.srca = 2'b01; c.aluc = 4'b0110; c.pcsrc = 2'b01; c.branch = 1'b1; end
      11: begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      12: begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.regdst = 2'b10; c.m2r = 2'b10; c.regwrite = 1'b1; end
      13: begin c.pcsrc = 2'b11; c.pcwrite = 1'b1; end
      14: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // The list of states an instruction walks through with no memory stalls.
  task automatic load_path(input logic [5:0] op, input logic [5:0] fn);
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(1);
    case (op)
      6'h23: begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
      6'h2B: begin exp_q.push_back(2); exp_q.push_back(5); end
      6'h00: begin
        if (fn == 6'h08) exp_q.push_back(13);
        else if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02}) begin
          exp_q.push_back(6); exp_q.push_back(7);
        end else exp_q.push_back(14);
      end
      6'h08: begin exp_q.push_back(8); exp_q.push_back(9); end
      6'h04: exp_q.push_back(10);
      6'h02: exp_q.push_back(11);
      6'h03: exp_q.push_back(12);
      default: exp_q.push_back(14);
    endcase
  endtask

  // One clock cycle: drive mem_ready, compare against the head of the path, then advance it.
  task automatic tick(input logic mr);
    int e;
    @(negedge clk);
    mem_ready = mr;
    #1;
    dut_st = int'(state);
    e = (exp_q.size() > 0) ? exp_q[0] : 0;
    chk("state", 32'(state), 32'(e));
    chk("ctrl", 32'(act_c), 32'(exp_ctrl(e, Funct, mr)));
    if (MemWrite) mw_cnt++;
    if (e != 14 && !((e == 0 || e == 3 || e == 5) && !mr) && exp_q.size() > 0)
      void'(exp_q.pop_front());
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic rnd,
                           output int lat, output int ex);
    int n;
    Opcode = op;
    Funct  = fn;
    load_path(op, fn);
    n   = 0;
    lat = 1;
    ex  = -1;
    while (exp_q.size() > 0 && n < 100) begin
      tick(rnd ? logic'($urandom_range(0, 3) != 0) : 1'b1);
      if (dut_st != 0) lat++;
      if (n == 2) ex = dut_st;
      n++;
    end
  endtask

  task automatic do_reset_pulse();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_ctrl", 32'(act_c), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, ex;
    tbl[0]  = '{6'h23, 6'h00, 5, 2};
    tbl[1]  = '{6'h2B, 6'h00, 4, 2};
    tbl[2]  = '{6'h00, 6'h20, 4, 6};
    tbl[3]  = '{6'h00, 6'h22, 4, 6};
    tbl[4]  = '{6'h00, 6'h24, 4, 6};
    tbl[5]  = '{6'h00, 6'h25, 4, 6};
    tbl[6]  = '{6'h00, 6'h2A, 4, 6};
    tbl[7]  = '{6'h00, 6'h00, 4, 6};
    tbl[8]  = '{6'h00, 6'h02, 4, 6};
    tbl[9]  = '{6'h00, 6'h08, 3, 13};
    tbl[10] = '{6'h08, 6'h11, 4, 8};
    tbl[11] = '{6'h04, 6'h00, 3, 10};
    tbl[12] = '{6'h02, 6'h3F, 3, 11};
    tbl[13] = '{6'h03, 6'h00, 3, 12};

    rst_n = 1'b0; mem_ready = 1'b1; Opcode = 6'h00; Funct = 6'h00; mw_cnt = 0;
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctrl", 32'(act_c), 32'd0);
    @(negedge clk);
    #1;
    chk("reset_irwrite", 32'(IRWrite), 32'd0);
    chk("reset_pcwrite", 32'(PCWrite), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, 1'b0, lat, ex);
      chk($sformatf("latency[%0d]", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("exec_state[%0d]", i), 32'(ex), 32'(tbl[i].exec_st));
      @(posedge clk);
      #1;
      chk($sformatf("back_to_fetch[%0d]", i), 32'(state), 32'd0);
    end

    // sw held in MEMWR for 3 stall cycles
    Opcode = 6'h2B; Funct = 6'h00; load_path(6'h2B, 6'h00);
    tick(1'b1); tick(1'b1); tick(1'b1);
    mw_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick(k == 3);
      chk("sw_iord", 32'(IorD), 32'd1);
    end
    chk("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);
    @(posedge clk);
    #1;
    chk("sw_done_state", 32'(state), 32'd0);

    // sll
    Opcode = 6'h00; Funct = 6'h00; load_path(6'h00, 6'h00);
    tick(1'b1); tick(1'b1); tick(1'b1);
    chk("sll_srca", 32'(ALUSrcA), 32'd2);
    chk("sll_aluc", 32'(ALUControl), 32'h8);
    tick(1'b1);
    chk("sll_regdst", 32'(RegDst), 32'd1);

    // beq then jal
    Opcode = 6'h04; load_path(6'h04, 6'h00);
    tick(1'b1); tick(1'b1); tick(1'b1);
    chk("beq_branch", 32'(Branch), 32'd1);
    chk("beq_pcsrc", 32'(PCSrc), 32'd1);
    chk("beq_aluc", 32'(ALUControl), 32'h6);
    Opcode = 6'h03; load_path(6'h03, 6'h00);
    tick(1'b1); tick(1'b1); tick(1'b1);
    chk("jal_regdst", 32'(RegDst), 32'd2);
    chk("jal_m2r", 32'(Mem2Reg), 32'd2);
    chk("jal_pcsrc", 32'(PCSrc), 32'd2);
    chk("jal_pcwrite", 32'(PCWrite), 32'd1);

    // randomized memory stalls over random legal instructions
    for (int i = 0; i < 150; i++) begin
      int idx;
      idx = $urandom_range(0, 13);
      run_instr(tbl[idx].op, tbl[idx].fn, 1'b1, lat, ex);
    end

    // illegal opcode and illegal funct: absorbing HALT, left by reset only
    for (int h = 0; h < 2; h++) begin
      Opcode = (h == 0) ? 6'h3F : 6'h00;
      Funct  = (h == 0) ? 6'h00 : 6'h01;
      load_path(Opcode, Funct);
      tick(1'b1); tick(1'b1);
      for (int k = 0; k < 20; k++) begin
        tick(logic'($urandom_range(0, 1)));
        chk("halt_halted", 32'(halted), 32'd1);
      end
      do_reset_pulse();
      run_instr(6'h08, 6'h00, 1'b0, lat, ex);
      chk("post_halt_latency", 32'(lat), 32'd4);
    end

    // reset asserted inside a MEMRD stall
    Opcode = 6'h23; Funct = 6'h00; load_path(6'h23, 6'h00);
    tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b0);
    rst_n = 1'b0;
    #1;
    chk("memrd_rst_state", 32'(state), 32'd0);
    chk("memrd_rst_ctrl", 32'(act_c), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("memrd_rst_hold_state", 32'(state), 32'd0);
    chk("memrd_rst_regwrite", 32'(RegWrite), 32'd0);
    rst_n = 1'b1;
    run_instr(6'h04, 6'h00, 1'b0, lat, ex);
    chk("post_rst_latency", 32'(lat), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
